// File: rtl/emulador_hcsr04_pkg.sv
// Shared definitions for the HC-SR04 ultrasonic sensor emulator:
// FSM state encoding and default timing constants (50 MHz clock).
package emulador_hcsr04_pkg;

  typedef enum logic [3:0] {
    INICIAL      = 4'b0000,
    MEDE_TRIGGER = 4'b0001,
    ATRASO       = 4'b0010,
    GERA_ECHO    = 4'b0011,
    FIM          = 4'b0100,
    REJEITA      = 4'b0101
  } estado_t;

  localparam int CICLOS_TRIGGER_MIN_PADRAO = 500;    // 10 us
  localparam int CICLOS_ATRASO_PADRAO      = 10000;  // 200 us burst
  localparam int CICLOS_POR_CM_PADRAO      = 2941;   // 58.82 us per cm
  localparam int DIST_MAX_PADRAO           = 400;

  localparam int LARGURA_POR_CM = 12;
  localparam int LARGURA_CM     = 9;

endpackage

// File: rtl/contador_m.sv
// Generic modulo-M up counter with synchronous clear (zera), enable (conta)
// and a terminal-count flag (fim) that is high while q holds M-1.
module contador_m #(
  parameter int M = 10,
  parameter int N = (M > 1) ? $clog2(M) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [N-1:0] q,
  output logic         fim
);

  localparam logic [N-1:0] ULTIMO = N'(M - 1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (zera) begin
      q <= '0;
    end else if (conta) begin
      q <= (q == ULTIMO) ? '0 : q + 1'b1;
    end
  end

  assign fim = (q == ULTIMO);

endmodule

// File: rtl/emulador_hcsr04.sv
// HC-SR04 emulator: measures the trigger pulse, waits the burst time and
// produces an echo whose width is distancia x CICLOS_POR_CM clocks.
module emulador_hcsr04
  import emulador_hcsr04_pkg::*;
#(
  parameter int CICLOS_TRIGGER_MIN = CICLOS_TRIGGER_MIN_PADRAO,
  parameter int CICLOS_ATRASO      = CICLOS_ATRASO_PADRAO,
  parameter int CICLOS_POR_CM      = CICLOS_POR_CM_PADRAO,
  parameter int DIST_MAX           = DIST_MAX_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia,
  output logic       echo,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  localparam int LT = (CICLOS_TRIGGER_MIN > 1) ? $clog2(CICLOS_TRIGGER_MIN) : 1;
  localparam int LA = (CICLOS_ATRASO > 1) ? $clog2(CICLOS_ATRASO) : 1;

  estado_t estado, proximo;

  logic                      armado;
  logic [LARGURA_CM-1:0]     dist_reg;
  logic                      carrega_dist;
  logic                      dist_invalida;
  logic                      fim_trig, fim_atraso, fim_por_cm, fim_echo;
  logic [LARGURA_CM-1:0]     cm_q;
  logic [LT-1:0]             unused_q_trig;
  logic [LA-1:0]             unused_q_atraso;
  logic [LARGURA_POR_CM-1:0] unused_q_por_cm;
  logic                      unused_fim_cm;

  // ---------------- control FSM ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo;
  end

  // NOTE: defaults first so no path leaves proximo/carrega_dist unassigned (no latch).
  always_comb begin
    proximo      = estado;
    carrega_dist = 1'b0;
    unique case (estado)
      INICIAL:      if (trigger && armado) proximo = MEDE_TRIGGER;
      MEDE_TRIGGER: if (!trigger) begin
                      if (!fim_trig) begin
                        proximo = REJEITA;
                      end else begin
                        carrega_dist = 1'b1;
                        proximo      = dist_invalida ? REJEITA : ATRASO;
                      end
                    end
      ATRASO:       if (fim_atraso) proximo = GERA_ECHO;
      GERA_ECHO:    if (fim_echo) proximo = FIM;
      FIM:          proximo = INICIAL;
      REJEITA:      proximo = INICIAL;
      default:      proximo = INICIAL;
    endcase
  end

  // ---------------- datapath ----------------
  assign dist_invalida = (distancia == '0) || (int'(distancia) > DIST_MAX);

  // Start needs trigger seen low while idle, so a level held over fim or reset is ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo     <= 1'b0;
      armado   <= 1'b0;
      dist_reg <= '0;
    end else begin
      echo   <= (proximo == GERA_ECHO);
      armado <= (estado == INICIAL) && (armado || !trigger);
      if (carrega_dist) dist_reg <= distancia;
    end
  end

  // Trigger counter saturates at M-1: the detection cycle in inicial is the first high cycle.
  contador_m #(.M(CICLOS_TRIGGER_MIN), .N(LT)) u_cont_trigger (
    .clock (clock),
    .reset (reset),
    .zera  (estado != MEDE_TRIGGER),
    .conta ((estado == MEDE_TRIGGER) && trigger && !fim_trig),
    .q     (unused_q_trig),
    .fim   (fim_trig)
  );

  contador_m #(.M(CICLOS_ATRASO), .N(LA)) u_cont_atraso (
    .clock (clock),
    .reset (reset),
    .zera  (estado != ATRASO),
    .conta (estado == ATRASO),
    .q     (unused_q_atraso),
    .fim   (fim_atraso)
  );

  contador_m #(.M(CICLOS_POR_CM), .N(LARGURA_POR_CM)) u_cont_por_cm (
    .clock (clock),
    .reset (reset),
    .zera  (estado != GERA_ECHO),
    .conta (estado == GERA_ECHO),
    .q     (unused_q_por_cm),
    .fim   (fim_por_cm)
  );

  contador_m #(.M(2 ** LARGURA_CM), .N(LARGURA_CM)) u_cont_cm (
    .clock (clock),
    .reset (reset),
    .zera  (estado != GERA_ECHO),
    .conta ((estado == GERA_ECHO) && fim_por_cm),
    .q     (cm_q),
    .fim   (unused_fim_cm)
  );

  // Last cycle of the last centimetre closes the echo.
  assign fim_echo = (estado == GERA_ECHO) && fim_por_cm && (cm_q == dist_reg - 9'd1);

  assign pronto    = (estado == FIM);
  assign erro      = (estado == REJEITA);
  assign db_estado = estado;

endmodule

// File: tb/tb_emulador_hcsr04.sv
// Randomized self-checking bench for emulador_hcsr04 with scaled timing;
// expected echo timing is computed arithmetically from trigger width and distance.
module tb_emulador_hcsr04;

  localparam int TMIN = 8;
  localparam int ATR  = 20;
  localparam int PCM  = 5;
  localparam int DMAX = 40;

  logic       clock = 1'b0;
  logic       reset;
  logic       trigger;
  logic [8:0] distancia;
  logic       echo, pronto, erro;
  logic [3:0] db_estado;

  emulador_hcsr04 #(
    .CICLOS_TRIGGER_MIN (TMIN),
    .CICLOS_ATRASO      (ATR),
    .CICLOS_POR_CM      (PCM),
    .DIST_MAX           (DMAX)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .trigger   (trigger),
    .distancia (distancia),
    .echo      (echo),
    .pronto    (pronto),
    .erro      (erro),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   high_cnt, rise_cnt, pronto_cnt, erro_cnt;
  int   rise_cyc, pronto_cyc, erro_cyc;
  logic echo_prev;
  bit   mess = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    high_cnt = 0; rise_cnt = 0; pronto_cnt = 0; erro_cnt = 0;
    rise_cyc = -1; pronto_cyc = -1; erro_cyc = -1;
    echo_prev = echo;
  endtask

  // One clock: sample outputs on the falling edge, then optionally scramble inputs.
  task automatic step();
    @(negedge clock);
    cyc++;
    if (echo === 1'b1) begin
      high_cnt++;
      if (echo_prev !== 1'b1) begin
        rise_cnt++;
        rise_cyc = cyc;
      end
    end
    if (pronto === 1'b1) begin pronto_cnt++; pronto_cyc = cyc; end
    if (erro === 1'b1)   begin erro_cnt++;   erro_cyc = cyc;   end
    echo_prev = echo;
    check("pronto_erro_excl", 64'(pronto & erro), 64'(0));
    check("echo_only_in_gera", 64'(echo), 64'(db_estado == 4'd3));
    if (mess) begin
      trigger   = 1'($urandom_range(0, 1));
      distancia = 9'($urandom_range(0, 511));
    end
  endtask

  // Trigger high for w sampled edges; c_fall is the cycle whose edge first sees it low.
  task automatic pulse_trigger(input int w, input int d, output int c_fall);
    trigger   = 1'b1;
    distancia = 9'(d);
    repeat (w) step();
    trigger = 1'b0;
    c_fall  = cyc + 1;
  endtask

  task automatic run_measure(input int w, input int d, input bit do_mess, input bit do_hold);
    int c_fall;
    int bound;
    int busy;
    bit valid;
    valid = (w >= TMIN) && (d >= 1) && (d <= DMAX);
    trigger = 1'b0;
    step();
    step();
    clear_stats();
    pulse_trigger(w, d, c_fall);
    mess  = do_mess;
    bound = ATR + d * PCM + 10;
    while ((pronto_cnt + erro_cnt) == 0 && bound > 0) begin
      step();
      bound--;
      if (do_hold && high_cnt > 0) trigger = 1'b1;
    end
    mess = 1'b0;
    if (!do_hold) trigger = 1'b0;
    check("measure_done", 64'((pronto_cnt + erro_cnt) > 0), 64'(1));
    step();
    check("back_to_inicial", 64'(db_estado), 64'(0));
    busy = 0;
    repeat (do_hold ? 10 : 3) begin
      step();
      if (db_estado !== 4'd0) busy++;
    end
    check(do_hold ? "held_trigger_idle" : "idle_after", 64'(busy), 64'(0));
    if (valid) begin
      check("echo_rises", 64'(rise_cnt), 64'(1));
      check("echo_rise_cycle", 64'(rise_cyc), 64'(c_fall + ATR));
      check("echo_width", 64'(high_cnt), 64'(d * PCM));
      check("pronto_count", 64'(pronto_cnt), 64'(1));
      check("pronto_cycle", 64'(pronto_cyc), 64'(c_fall + ATR + d * PCM));
      check("no_erro", 64'(erro_cnt), 64'(0));
    end else begin
      check("erro_count", 64'(erro_cnt), 64'(1));
      check("erro_cycle", 64'(erro_cyc), 64'(c_fall));
      check("no_echo", 64'(high_cnt), 64'(0));
      check("no_pronto", 64'(pronto_cnt), 64'(0));
    end
    trigger = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c_fall;
    int bound;
    int busy;
    int w, d, sel;

    reset     = 1'b1;
    trigger   = 1'b0;
    distancia = '0;
    step();
    step();
    check("rst_echo", 64'(echo), 64'(0));
    check("rst_pronto", 64'(pronto), 64'(0));
    check("rst_erro", 64'(erro), 64'(0));
    check("rst_state", 64'(db_estado), 64'(0));
    reset = 1'b0;

    // Directed scenarios
    run_measure(TMIN, 10, 1'b0, 1'b0);       // nominal
    run_measure(TMIN - 1, 10, 1'b0, 1'b0);   // short trigger
    run_measure(TMIN, 0, 1'b0, 1'b0);        // zero distance
    run_measure(TMIN, DMAX + 1, 1'b0, 1'b0); // beyond range
    run_measure(TMIN, DMAX, 1'b0, 1'b0);     // largest valid
    run_measure(TMIN + 50, 3, 1'b0, 1'b0);   // long trigger saturates
    run_measure(TMIN, 5, 1'b1, 1'b0);        // input noise during measurement
    run_measure(TMIN, 7, 1'b0, 1'b1);        // trigger held across fim
    run_measure(TMIN, 1, 1'b0, 1'b0);        // smallest valid

    // Reset in the middle of an echo
    trigger = 1'b0;
    step();
    step();
    clear_stats();
    pulse_trigger(TMIN, 10, c_fall);
    bound = ATR + 30;
    while (high_cnt < 17 && bound > 0) begin
      step();
      bound--;
    end
    check("rst_mid_reached", 64'(high_cnt), 64'(17));
    reset = 1'b1;
    #1;
    check("rst_mid_echo", 64'(echo), 64'(0));
    check("rst_mid_state", 64'(db_estado), 64'(0));
    trigger = 1'b1;
    step();
    step();
    reset = 1'b0;
    busy  = 0;
    repeat (TMIN + 3) begin
      step();
      if (db_estado !== 4'd0) busy++;
    end
    check("rst_needs_fresh_trigger", 64'(busy), 64'(0));
    check("rst_mid_no_pronto", 64'(pronto_cnt), 64'(0));
    check("rst_mid_no_erro", 64'(erro_cnt), 64'(0));
    check("rst_mid_width", 64'(high_cnt), 64'(17));
    trigger = 1'b0;
    run_measure(TMIN, 10, 1'b0, 1'b0);

    // Randomized measurements
    for (int i = 0; i < 24; i++) begin
      w   = $urandom_range(TMIN - 2, TMIN + 6);
      sel = $urandom_range(0, 5);
      case (sel)
        0:       d = 0;
        1:       d = DMAX;
        2:       d = DMAX + 1;
        3:       d = $urandom_range(DMAX + 1, 511);
        default: d = $urandom_range(1, DMAX);
      endcase
      run_measure(w, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
